// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline's fetch/memory stages, the arbiter and the
// shared memory. The arbiter takes the slave view; the pipeline plus memory
// environment takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Fetch stage requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;

    // Memory stage requester
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall_mem;

    // Single-port memory side
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    // Sticky error flag
    logic              err;

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  dm_rd, dm_wr, dm_addr, dm_wdata,
        input  mem_done, mem_rdata,
        output if_done, if_rdata, stall_if,
        output dm_done, dm_rdata, stall_mem,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        output err
    );

    modport master (
        output if_req, if_addr, if_cancel,
        output dm_rd, dm_wr, dm_addr, dm_wdata,
        output mem_done, mem_rdata,
        input  if_done, if_rdata, stall_if,
        input  dm_done, dm_rdata, stall_mem,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one transaction at a time between the fetch
// stage and the memory stage, memory stage wins ties. A squashed fetch still
// runs to completion on the memory side but produces no done pulse. A
// watchdog ends any transaction whose mem_done never arrives.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        DM_WAIT,
        RESP
    } state_t;

    state_t            state;
    logic              mem_req_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_done_r;
    logic              dm_done_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              err_r;
    logic              cancel_r;
    logic [CNT_W-1:0]  wait_cnt;

    logic              dm_any;
    logic              cancel_now;
    logic              timeout_hit;

    // Saturating increment for the watchdog counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A flush seen in the completion cycle squashes the fetch just like an earlier one
    assign dm_any      = bus.dm_rd | bus.dm_wr;
    assign cancel_now  = cancel_r | bus.if_cancel;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Arbitration FSM with registered memory-side and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req_r   <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            err_r       <= 1'b0;
            cancel_r    <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            mem_req_r <= 1'b0;
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;

            // Conflicting MEM-stage command: flag it, the grant treats it as a write
            if (bus.dm_rd & bus.dm_wr) begin
                err_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    cancel_r <= 1'b0;
                    if (dm_any) begin
                        mem_req_r   <= 1'b1;
                        mem_wr_r    <= bus.dm_wr;
                        mem_addr_r  <= bus.dm_addr;
                        mem_wdata_r <= bus.dm_wdata;
                        state       <= DM_WAIT;
                    end else if (bus.if_req & ~bus.if_cancel) begin
                        mem_req_r  <= 1'b1;
                        mem_wr_r   <= 1'b0;
                        mem_addr_r <= bus.if_addr;
                        state      <= IF_WAIT;
                    end
                end

                IF_WAIT: begin
                    cancel_r <= cancel_now;
                    if (bus.mem_done) begin
                        if_done_r <= ~cancel_now;
                        if (!cancel_now) begin
                            if_rdata_r <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        err_r     <= 1'b1;
                        if_done_r <= ~cancel_now;
                        if (!cancel_now) begin
                            if_rdata_r <= '0;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                DM_WAIT: begin
                    if (bus.mem_done) begin
                        dm_done_r  <= 1'b1;
                        dm_rdata_r <= bus.mem_rdata;
                        state      <= RESP;
                    end else if (timeout_hit) begin
                        err_r      <= 1'b1;
                        dm_done_r  <= 1'b1;
                        dm_rdata_r <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                RESP: begin
                    // Done pulse is on the bus this cycle; no grant so requesters can drop
                    cancel_r <= 1'b0;
                    wait_cnt <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.err       = err_r;

    // Stalls drop combinationally in the done-pulse cycle
    assign bus.stall_if  = bus.if_req & ~if_done_r & ~bus.if_cancel;
    assign bus.stall_mem = dm_any & ~dm_done_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, a timestamp-based reference
// model compared every cycle, and literal expectations at key cycles.
module tb_mem_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    int              mem_lat;   // cycles from mem_req to mem_done; <=0 never answers
    logic [DATA_W-1:0] mem_data;
    int              pending;

    initial begin
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
        pending       = -1;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_done = 1'b0;
            if (rst) begin
                pending = -1;
            end else if (bus.mem_req) begin
                pending = mem_lat;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    bus.mem_done  = 1'b1;
                    bus.mem_rdata = mem_data;
                    pending       = -1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Transactions are tracked by cycle stamps: the cycle mem_req is issued,
    // the elapsed wait, and the first cycle a new grant may be decided.
    bit                m_valid = 0;
    bit                m_busy;
    bit                m_dm_owner;
    bit                m_cancel;
    int                t_req;
    int                free_cyc;
    logic              e_mem_req, e_if_done, e_dm_done, e_err, e_mem_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_if_rdata, e_dm_rdata;

    task automatic model_step();
        bit              finished;
        logic [DATA_W-1:0] data;
        e_mem_req = 1'b0;
        e_if_done = 1'b0;
        e_dm_done = 1'b0;
        if (rst) begin
            m_valid    = 1;
            m_busy     = 0;
            m_cancel   = 0;
            e_err      = 1'b0;
            e_mem_wr   = 1'b0;
            e_addr     = '0;
            e_wdata    = '0;
            e_if_rdata = '0;
            e_dm_rdata = '0;
            free_cyc   = cyc;
        end else if (m_valid) begin
            if (bus.dm_rd && bus.dm_wr) e_err = 1'b1;
            if (!m_busy) begin
                if (cyc - 1 >= free_cyc) begin
                    if (bus.dm_rd || bus.dm_wr) begin
                        m_busy = 1; m_dm_owner = 1; t_req = cyc; e_mem_req = 1'b1;
                        e_mem_wr = bus.dm_wr; e_addr = bus.dm_addr; e_wdata = bus.dm_wdata;
                    end else if (bus.if_req && !bus.if_cancel) begin
                        m_busy = 1; m_dm_owner = 0; t_req = cyc; e_mem_req = 1'b1;
                        e_mem_wr = 1'b0; e_addr = bus.if_addr;
                    end
                end
            end else begin
                finished = 0;
                data     = '0;
                if (!m_dm_owner && bus.if_cancel) m_cancel = 1;
                if (bus.mem_done) begin
                    finished = 1;
                    data     = bus.mem_rdata;
                end else if ((cyc - 1 - t_req) == TIMEOUT - 1) begin
                    finished = 1;
                    e_err    = 1'b1;
                end
                if (finished) begin
                    if (m_dm_owner) begin
                        e_dm_done  = 1'b1;
                        e_dm_rdata = data;
                    end else if (!m_cancel) begin
                        e_if_done  = 1'b1;
                        e_if_rdata = data;
                    end
                    m_busy   = 0;
                    m_cancel = 0;
                    free_cyc = cyc + 1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("mem_req",   bus.mem_req,   e_mem_req);
        chk("if_done",   bus.if_done,   e_if_done);
        chk("dm_done",   bus.dm_done,   e_dm_done);
        chk("if_rdata",  bus.if_rdata,  e_if_rdata);
        chk("dm_rdata",  bus.dm_rdata,  e_dm_rdata);
        chk("err",       bus.err,       e_err);
        chk("stall_if",  bus.stall_if,  bus.if_req & ~e_if_done & ~bus.if_cancel);
        chk("stall_mem", bus.stall_mem, (bus.dm_rd | bus.dm_wr) & ~e_dm_done);
        if (m_busy) begin
            chk("mem_wr",   bus.mem_wr,   e_mem_wr);
            chk("mem_addr", bus.mem_addr, e_addr);
            if (m_dm_owner) chk("mem_wdata", bus.mem_wdata, e_wdata);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            if (m_valid) compare();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_cancel = 1'b0;
        bus.dm_rd    = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        mem_lat      = -1;
        mem_data     = '0;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("rst_mem_req",  bus.mem_req,  0);
        chk("rst_mem_wr",   bus.mem_wr,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_done",  bus.if_done,  0);
        chk("rst_dm_done",  bus.dm_done,  0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_err",      bus.err,      0);

        // IF read 0x0010, memory answers 2 cycles after mem_req
        mem_lat = 2; mem_data = 16'hBEEF;
        bus.if_addr = 16'h0010; bus.if_req = 1'b1;
        #1 chk("if_stall_t0", bus.stall_if, 1);
        tick();
        chk("if_mem_req_t1",  bus.mem_req,  1);
        chk("if_mem_addr_t1", bus.mem_addr, 16'h0010);
        chk("if_mem_wr_t1",   bus.mem_wr,   0);
        tick(); tick();
        chk("if_stall_t3", bus.stall_if, 1);
        chk("if_done_t3",  bus.if_done,  0);
        tick();
        chk("if_done_t4",  bus.if_done,  1);
        chk("if_rdata_t4", bus.if_rdata, 16'hBEEF);
        chk("if_stall_t4", bus.stall_if, 0);
        bus.if_req = 1'b0;
        tick(); tick();

        // Same-cycle IF read and DM write: DM first
        mem_lat = 1; mem_data = 16'h5555;
        bus.if_addr = 16'h0020; bus.if_req = 1'b1;
        bus.dm_addr = 16'h8000; bus.dm_wdata = 16'h1234; bus.dm_wr = 1'b1;
        tick();
        chk("tie_mem_req",   bus.mem_req,   1);
        chk("tie_mem_wr",    bus.mem_wr,    1);
        chk("tie_mem_addr",  bus.mem_addr,  16'h8000);
        chk("tie_mem_wdata", bus.mem_wdata, 16'h1234);
        tick(); tick();
        chk("tie_dm_done", bus.dm_done, 1);
        bus.dm_wr = 1'b0;
        tick();
        chk("tie_gap_mem_req", bus.mem_req, 0);
        tick();
        chk("tie_if_mem_req",  bus.mem_req,  1);
        chk("tie_if_mem_wr",   bus.mem_wr,   0);
        chk("tie_if_mem_addr", bus.mem_addr, 16'h0020);
        tick(); tick();
        chk("tie_if_done",  bus.if_done,  1);
        chk("tie_if_rdata", bus.if_rdata, 16'h5555);
        bus.if_req = 1'b0;
        tick(); tick();

        // Fetch cancelled mid-wait
        mem_lat = 3; mem_data = 16'hAAAA;
        bus.if_addr = 16'h0030; bus.if_req = 1'b1;
        tick();
        chk("cxl_mem_req", bus.mem_req, 1);
        tick();
        bus.if_cancel = 1'b1;
        #1 chk("cxl_stall_if", bus.stall_if, 0);
        tick();
        bus.if_cancel = 1'b0; bus.if_req = 1'b0;
        tick(); tick();
        chk("cxl_if_done",  bus.if_done,  0);
        chk("cxl_if_rdata", bus.if_rdata, 16'h5555);
        tick();
        mem_lat = 1; mem_data = 16'h1357;
        bus.if_addr = 16'h0040; bus.if_req = 1'b1;
        tick(); tick(); tick();
        chk("post_cxl_if_done",  bus.if_done,  1);
        chk("post_cxl_if_rdata", bus.if_rdata, 16'h1357);
        bus.if_req = 1'b0;
        tick(); tick();

        // DM read never answered: watchdog
        mem_lat = -1;
        bus.dm_addr = 16'h0100; bus.dm_rd = 1'b1;
        repeat (TIMEOUT) tick();
        chk("to_dm_done_early", bus.dm_done, 0);
        chk("to_err_early",     bus.err,     0);
        tick();
        chk("to_dm_done",   bus.dm_done,   1);
        chk("to_dm_rdata",  bus.dm_rdata,  0);
        chk("to_err",       bus.err,       1);
        chk("to_stall_mem", bus.stall_mem, 0);
        bus.dm_rd = 1'b0;
        repeat (3) tick();
        chk("to_err_sticky", bus.err, 1);

        // dm_rd and dm_wr together
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("both_err_cleared", bus.err, 0);
        mem_lat = 1; mem_data = 16'h0F0F;
        bus.dm_addr = 16'h0200; bus.dm_wdata = 16'hCAFE;
        bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
        tick();
        chk("both_mem_req",   bus.mem_req,   1);
        chk("both_mem_wr",    bus.mem_wr,    1);
        chk("both_mem_wdata", bus.mem_wdata, 16'hCAFE);
        chk("both_err",       bus.err,       1);
        tick(); tick();
        chk("both_dm_done", bus.dm_done, 1);
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        tick(); tick();

        // Reset in the middle of a DM wait
        rst = 1'b1; tick(); rst = 1'b0; tick();
        mem_lat = -1;
        bus.dm_addr = 16'h0300; bus.dm_rd = 1'b1;
        tick();
        chk("mid_mem_req", bus.mem_req, 1);
        tick(); tick();
        rst = 1'b1; bus.dm_rd = 1'b0;
        tick();
        chk("mid_dm_done",  bus.dm_done,  0);
        chk("mid_mem_req0", bus.mem_req,  0);
        chk("mid_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        repeat (10) tick();
        mem_lat = 1; mem_data = 16'h2468;
        bus.if_addr = 16'h0050; bus.if_req = 1'b1;
        tick();
        chk("mid_if_mem_req", bus.mem_req, 1);
        tick(); tick();
        chk("mid_if_done",  bus.if_done,  1);
        chk("mid_if_rdata", bus.if_rdata, 16'h2468);
        bus.if_req = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
